// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported unified memory between instruction fetch (I) and
//   MEM-stage data access (D). The winning request is registered onto the
//   memory port, held until mem_ack (or a wait timeout), and completion is
//   returned to the winner as a one-cycle ready with combinational read data.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   if_req/if_addr            fetch request and address
//   if_rdata/if_ready         fetch data and one-cycle completion pulse
//   dm_req/dm_we/dm_be        data request, store flag, byte enables
//   dm_addr/dm_wdata          data address and store data
//   dm_rdata/dm_ready         load data and one-cycle completion pulse
//   mem_req/mem_we/mem_be     registered memory request fields
//   mem_addr/mem_wdata        registered memory address and write data
//   mem_rdata/mem_ack         memory read data and completion
//   stall_f/stall_m           requester waiting (req & ~ready)
//   bus_err                   sticky timeout flag, cleared only by rst
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_ready,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [DATA_W/8-1:0] dm_be,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                dm_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack,
  output logic                stall_f,
  output logic                stall_m,
  output logic                bus_err
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_mem_req,   w_mem_req_nxt;
  logic                r_mem_we,    w_mem_we_nxt;
  logic [BE_W-1:0]     r_mem_be,    w_mem_be_nxt;
  logic [ADDR_W-1:0]   r_mem_addr,  w_mem_addr_nxt;
  logic [DATA_W-1:0]   r_mem_wdata, w_mem_wdata_nxt;
  logic [CNT_W-1:0]    r_cnt,       w_cnt_nxt;
  logic                r_last_d,    w_last_d_nxt;
  logic                r_bus_err,   w_bus_err_nxt;

  logic                w_grant_d;
  logic                w_timeout;
  logic                w_done;
  logic                w_if_ready;
  logic                w_dm_ready;
  logic [DATA_W-1:0]   w_if_rdata;
  logic [DATA_W-1:0]   w_dm_rdata;

  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));

  always_comb begin
    w_state_nxt     = r_state;
    w_mem_req_nxt   = r_mem_req;
    w_mem_we_nxt    = r_mem_we;
    w_mem_be_nxt    = r_mem_be;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_cnt_nxt       = r_cnt;
    w_last_d_nxt    = r_last_d;
    w_bus_err_nxt   = r_bus_err;
    w_grant_d       = 1'b0;
    w_done          = 1'b0;
    w_if_ready      = 1'b0;
    w_dm_ready      = 1'b0;
    w_if_rdata      = '0;
    w_dm_rdata      = '0;

    case (r_state)
      IDLE: begin
        if (if_req || dm_req) begin
          // D wins when alone, or on a tie when I was granted last
          w_grant_d     = dm_req & (~if_req | ~r_last_d);
          w_last_d_nxt  = w_grant_d;
          w_mem_req_nxt = 1'b1;
          w_cnt_nxt     = '0;
          if (w_grant_d) begin
            w_mem_we_nxt    = dm_we;
            w_mem_be_nxt    = dm_be;
            w_mem_addr_nxt  = dm_addr;
            w_mem_wdata_nxt = dm_wdata;
            w_state_nxt     = SERVE_D;
          end else begin
            w_mem_we_nxt    = 1'b0;
            w_mem_be_nxt    = '1;
            w_mem_addr_nxt  = if_addr;
            w_mem_wdata_nxt = '0;
            w_state_nxt     = SERVE_I;
          end
        end
      end
      SERVE_I, SERVE_D: begin
        // an ack coinciding with the timeout cycle is a normal completion
        w_done = mem_ack | w_timeout;
        if (w_done) begin
          if (r_state == SERVE_I) begin
            w_if_ready = 1'b1;
            w_if_rdata = mem_ack ? mem_rdata : '0;
          end else begin
            w_dm_ready = 1'b1;
            w_dm_rdata = mem_ack ? mem_rdata : '0;
          end
          if (!mem_ack) begin
            w_bus_err_nxt = 1'b1;
          end
          w_mem_req_nxt = 1'b0;
          w_cnt_nxt     = '0;
          w_state_nxt   = IDLE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_mem_req_nxt = 1'b0;
        w_state_nxt   = IDLE;
      end
    endcase

    // a transaction aborted by reset must not report completion
    if (rst) begin
      w_if_ready = 1'b0;
      w_dm_ready = 1'b0;
      w_if_rdata = '0;
      w_dm_rdata = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_be    <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_cnt       <= '0;
      r_last_d    <= 1'b0;
      r_bus_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_mem_req   <= w_mem_req_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_be    <= w_mem_be_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_cnt       <= w_cnt_nxt;
      r_last_d    <= w_last_d_nxt;
      r_bus_err   <= w_bus_err_nxt;
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_be    = r_mem_be;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign bus_err   = r_bus_err;
  assign if_ready  = w_if_ready;
  assign dm_ready  = w_dm_ready;
  assign if_rdata  = w_if_rdata;
  assign dm_rdata  = w_dm_rdata;
  assign stall_f   = if_req & ~w_if_ready;
  assign stall_m   = dm_req & ~w_dm_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed bench for mem_port_arbiter. Requests push the expected memory
//   transaction onto a scoreboard; the bench plays the memory, acking after a
//   chosen delay with the scoreboard read data, and pops/compares when the
//   ready pulse appears.
module tb_mem_port_arbiter;

  localparam int TO = 8;

  typedef struct packed {
    logic        is_d;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        dm_req;
  logic        dm_we;
  logic [3:0]  dm_be;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ready;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        stall_f;
  logic        stall_m;
  logic        bus_err;

  int   n_cmp;
  int   n_err;
  exp_t sb[$];

  mem_port_arbiter #(
    .ADDR_W (32),
    .DATA_W (32),
    .TIMEOUT(TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_ready (if_ready),
    .dm_req   (dm_req),
    .dm_we    (dm_we),
    .dm_be    (dm_be),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_rdata (dm_rdata),
    .dm_ready (dm_ready),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_be   (mem_be),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack),
    .stall_f  (stall_f),
    .stall_m  (stall_m),
    .bus_err  (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    mem_ack = 1'b0;
  endtask

  task automatic req_i(input logic [31:0] addr, input logic [31:0] rd);
    exp_t e;
    e = '{is_d: 1'b0, addr: addr, we: 1'b0, be: 4'hF, wdata: 32'h0, rdata: rd};
    sb.push_back(e);
    if_req  = 1'b1;
    if_addr = addr;
  endtask

  task automatic req_d(input logic we, input logic [3:0] be, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] rd);
    exp_t e;
    e = '{is_d: 1'b1, addr: addr, we: we, be: be, wdata: wd, rdata: rd};
    sb.push_back(e);
    dm_req   = 1'b1;
    dm_we    = we;
    dm_be    = be;
    dm_addr  = addr;
    dm_wdata = wd;
  endtask

  // IDLE cycle: nothing on the memory port, nobody ready, requesters stalled
  task automatic idle_cycle(input string tag);
    #1;
    chk({tag, "_mem_req"},  32'(mem_req),  32'd0);
    chk({tag, "_if_ready"}, 32'(if_ready), 32'd0);
    chk({tag, "_dm_ready"}, 32'(dm_ready), 32'd0);
    chk({tag, "_stall_f"},  32'(stall_f),  32'(if_req));
    chk({tag, "_stall_m"},  32'(stall_m),  32'(dm_req));
  endtask

  // serve the scoreboard head; delay<0 means never ack (timeout expected)
  task automatic serve(input string tag, input int delay);
    exp_t        e;
    int          lim;
    bit          to;
    logic [31:0] exp_rd;
    if (sb.size() == 0) begin
      chk({tag, "_sb_nonempty"}, 32'd0, 32'd1);
      return;
    end
    e      = sb[0];
    to     = (delay < 0);
    lim    = to ? TO - 1 : delay;
    exp_rd = to ? 32'h0 : e.rdata;
    for (int k = 0; k <= lim; k++) begin
      tick();
      mem_ack   = (k == delay);
      mem_rdata = (k == delay) ? e.rdata : (32'hBAD0_0000 | 32'(k));
      #1;
      chk({tag, "_mem_req"},   32'(mem_req), 32'd1);
      chk({tag, "_mem_addr"},  mem_addr,     e.addr);
      chk({tag, "_mem_we"},    32'(mem_we),  32'(e.we));
      chk({tag, "_mem_be"},    32'(mem_be),  32'(e.be));
      chk({tag, "_mem_wdata"}, mem_wdata,    e.wdata);
      if (k == lim) begin
        void'(sb.pop_front());
        chk({tag, "_if_ready"}, 32'(if_ready), 32'(!e.is_d));
        chk({tag, "_dm_ready"}, 32'(dm_ready), 32'(e.is_d));
        chk({tag, "_rdata"}, e.is_d ? dm_rdata : if_rdata, exp_rd);
        chk({tag, "_stall_done"}, 32'(e.is_d ? stall_m : stall_f), 32'd0);
      end else begin
        chk({tag, "_if_ready_wait"}, 32'(if_ready), 32'd0);
        chk({tag, "_dm_ready_wait"}, 32'(dm_ready), 32'd0);
        chk({tag, "_stall_wait"}, 32'(e.is_d ? stall_m : stall_f), 32'd1);
      end
    end
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst       = 1'b1;
    if_req    = 1'b0;
    if_addr   = 32'h0;
    dm_req    = 1'b0;
    dm_we     = 1'b0;
    dm_be     = 4'h0;
    dm_addr   = 32'h0;
    dm_wdata  = 32'h0;
    mem_rdata = 32'h0;
    mem_ack   = 1'b0;

    // reset state
    tick();
    tick();
    #1;
    chk("rst_mem_req",   32'(mem_req),   32'd0);
    chk("rst_mem_we",    32'(mem_we),    32'd0);
    chk("rst_mem_be",    32'(mem_be),    32'd0);
    chk("rst_mem_addr",  mem_addr,       32'd0);
    chk("rst_mem_wdata", mem_wdata,      32'd0);
    chk("rst_if_ready",  32'(if_ready),  32'd0);
    chk("rst_dm_ready",  32'(dm_ready),  32'd0);
    chk("rst_if_rdata",  if_rdata,       32'd0);
    chk("rst_dm_rdata",  dm_rdata,       32'd0);
    chk("rst_stall_f",   32'(stall_f),   32'd0);
    chk("rst_stall_m",   32'(stall_m),   32'd0);
    chk("rst_bus_err",   32'(bus_err),   32'd0);
    rst = 1'b0;
    // stray acks while idle are ignored
    for (int i = 0; i < 3; i++) begin
      tick();
      mem_ack   = 1'b1;
      mem_rdata = 32'h1234_0000 | 32'(i);
      #1;
      chk("post_rst_mem_req",  32'(mem_req),  32'd0);
      chk("post_rst_if_ready", 32'(if_ready), 32'd0);
      chk("post_rst_dm_ready", 32'(dm_ready), 32'd0);
    end

    // single fetch, zero-wait ack
    tick();
    req_i(32'h100, 32'h0050_0093);
    idle_cycle("fetch_req");
    serve("fetch", 0);
    if_req = 1'b0;
    tick();
    idle_cycle("fetch_after");

    // both request: round robin D,I,D,I
    tick();
    req_d(1'b1, 4'hF, 32'h2000, 32'hDEAD_BEEF, 32'h0);
    req_i(32'h104, 32'h0000_0013);
    req_d(1'b1, 4'hF, 32'h2000, 32'hDEAD_BEEF, 32'h0);
    req_i(32'h104, 32'h0000_0013);
    idle_cycle("rr_req");
    serve("rr_d1", 0);
    tick();
    idle_cycle("rr_gap1");
    serve("rr_i1", 0);
    tick();
    idle_cycle("rr_gap2");
    serve("rr_d2", 1);
    tick();
    idle_cycle("rr_gap3");
    serve("rr_i2", 0);
    if_req = 1'b0;
    dm_req = 1'b0;
    tick();
    idle_cycle("rr_after");

    // load with three wait cycles
    tick();
    req_d(1'b0, 4'hF, 32'h3000, 32'h0, 32'hCAFE_F00D);
    idle_cycle("load_req");
    serve("load_wait3", 3);
    dm_req = 1'b0;
    tick();
    idle_cycle("load_after");

    // ack arriving in the timeout cycle completes normally
    tick();
    req_i(32'h200, 32'h1234_5678);
    idle_cycle("edge_req");
    serve("edge_ack", TO - 1);
    if_req = 1'b0;
    tick();
    idle_cycle("edge_after");
    chk("edge_bus_err", 32'(bus_err), 32'd0);

    // no ack at all: timeout
    tick();
    req_d(1'b0, 4'h3, 32'h4000, 32'h0, 32'h5A5A_5A5A);
    idle_cycle("to_req");
    serve("timeout", -1);
    dm_req = 1'b0;
    tick();
    idle_cycle("to_after");
    chk("to_bus_err", 32'(bus_err), 32'd1);

    // bus_err remains set through a good transaction
    tick();
    req_i(32'h300, 32'hAAAA_5555);
    idle_cycle("sticky_req");
    serve("sticky", 2);
    if_req = 1'b0;
    tick();
    idle_cycle("sticky_after");
    chk("sticky_bus_err", 32'(bus_err), 32'd1);

    // reset in the middle of a fetch, followed by a late ack
    tick();
    req_i(32'h400, 32'h0000_0055);
    idle_cycle("abort_req");
    tick();
    #1;
    chk("abort_mem_req", 32'(mem_req), 32'd1);
    tick();
    rst    = 1'b1;
    if_req = 1'b0;
    #1;
    chk("abort_rst_if_ready", 32'(if_ready), 32'd0);
    tick();
    rst       = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 32'h0000_0055;
    #1;
    chk("abort_late_mem_req",  32'(mem_req),  32'd0);
    chk("abort_late_if_ready", 32'(if_ready), 32'd0);
    chk("abort_bus_err",       32'(bus_err),  32'd0);
    void'(sb.pop_front());
    tick();
    req_i(32'h404, 32'h0000_0077);
    idle_cycle("resume_req");
    serve("resume", 0);
    if_req = 1'b0;
    tick();
    idle_cycle("resume_after");
    chk("resume_bus_err", 32'(bus_err), 32'd0);

    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
